// File: rtl/sim_test_monitor.sv
// ============================================================================
// Module   : sim_test_monitor
// Brief    : End-of-test monitor; shadows per-hart done/pass registers and
//            produces a sticky PASS/FAIL/TIMEOUT verdict.
// Revision : 1.0
// ============================================================================
`default_nettype none

module sim_test_monitor #(
    parameter int NHART          = 1,
    parameter int XLEN           = 32,
    parameter int DONE_REG       = 26,
    parameter int PASS_REG       = 27,
    parameter int SETTLE_CYCLES  = 5,
    parameter int TIMEOUT_CYCLES = 5000,
    parameter int CNT_W          = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NHART-1:0]        rf_we,
    input  logic [5*NHART-1:0]      rf_waddr,
    input  logic [XLEN*NHART-1:0]   rf_wdata,
    output logic [1:0]              status,
    output logic                    finish,
    output logic [NHART-1:0]        hart_done,
    output logic [NHART-1:0]        fail_mask,
    output logic [CNT_W-1:0]        cycle_count
);

    localparam int                SETTLE_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0] C_SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  C_TIMEOUT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [4:0]        C_DONE_IDX     = 5'(DONE_REG);
    localparam logic [4:0]        C_PASS_IDX     = 5'(PASS_REG);
    localparam logic [XLEN-1:0]   C_ONE          = XLEN'(1);

    localparam logic [1:0] C_ST_RUN     = 2'd0;
    localparam logic [1:0] C_ST_PASS    = 2'd1;
    localparam logic [1:0] C_ST_FAIL    = 2'd2;
    localparam logic [1:0] C_ST_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_RUN     = 3'd0,
        S_SETTLE  = 3'd1,
        S_PASS    = 3'd2,
        S_FAIL    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    state_t                r_state;
    logic [1:0]            r_status;
    logic                  r_finish;
    logic [NHART-1:0]      r_hart_done;
    logic [NHART-1:0]      r_fail_mask;
    logic [CNT_W-1:0]      r_cycle_count;
    logic [SETTLE_W-1:0]   r_settle_cnt;

    logic                  w_active;
    logic                  w_timeout;
    logic [NHART-1:0]      w_done_one;
    logic [NHART-1:0]      w_pass_one;

    // Shadows only track the harts while a verdict is still pending.
    assign w_active  = (r_state == S_RUN) || (r_state == S_SETTLE);
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cycle_count == C_TIMEOUT_LAST);

    generate
        for (genvar h = 0; h < NHART; h++) begin : g_hart
            logic [4:0]      w_waddr;
            logic [XLEN-1:0] w_wdata;
            logic            w_wr_ok;
            logic [XLEN-1:0] r_done_sh;
            logic [XLEN-1:0] r_pass_sh;

            assign w_waddr = rf_waddr[5*h +: 5];
            assign w_wdata = rf_wdata[XLEN*h +: XLEN];
            assign w_wr_ok = w_active && rf_we[h] && (w_waddr != 5'd0);

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_done_sh <= '0;
                    r_pass_sh <= '0;
                end else if (w_wr_ok) begin
                    if (w_waddr == C_DONE_IDX) begin
                        r_done_sh <= w_wdata;
                    end
                    if (w_waddr == C_PASS_IDX) begin
                        r_pass_sh <= w_wdata;
                    end
                end
            end

            assign w_done_one[h] = (r_done_sh == C_ONE);
            assign w_pass_one[h] = (r_pass_sh == C_ONE);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_RUN;
            r_status      <= C_ST_RUN;
            r_finish      <= 1'b0;
            r_hart_done   <= '0;
            r_fail_mask   <= '0;
            r_cycle_count <= '0;
            r_settle_cnt  <= '0;
        end else begin
            r_finish <= 1'b0;
            if (w_active) begin
                if (r_cycle_count != '1) begin
                    r_cycle_count <= r_cycle_count + CNT_W'(1);
                end
                r_hart_done <= r_hart_done | w_done_one;
            end
            case (r_state)
                S_RUN: begin
                    if (w_timeout) begin
                        r_state  <= S_TIMEOUT;
                        r_status <= C_ST_TIMEOUT;
                        r_finish <= 1'b1;
                    end else if (&r_hart_done) begin
                        r_state      <= S_SETTLE;
                        r_settle_cnt <= '0;
                    end
                end
                S_SETTLE: begin
                    // A verdict on the same cycle as the timeout takes priority.
                    if (r_settle_cnt == C_SETTLE_LAST) begin
                        r_finish <= 1'b1;
                        if (&w_pass_one) begin
                            r_state  <= S_PASS;
                            r_status <= C_ST_PASS;
                        end else begin
                            r_state     <= S_FAIL;
                            r_status    <= C_ST_FAIL;
                            r_fail_mask <= ~w_pass_one;
                        end
                    end else if (w_timeout) begin
                        r_state  <= S_TIMEOUT;
                        r_status <= C_ST_TIMEOUT;
                        r_finish <= 1'b1;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + SETTLE_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign status      = r_status;
    assign finish      = r_finish;
    assign hart_done   = r_hart_done;
    assign fail_mask   = r_fail_mask;
    assign cycle_count = r_cycle_count;

endmodule

`default_nettype wire
